// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port, register 0 hardwired to zero, asynchronous active-high clear.
module reg_file #(
  parameter int reg_word_width = 32,
  parameter int reg_addr_width = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [reg_addr_width-1:0] READ_REG1_i,
  input  logic [reg_addr_width-1:0] READ_REG2_i,
  output logic [reg_word_width-1:0] READ_DATA1_o,
  output logic [reg_word_width-1:0] READ_DATA2_o,
  input  logic [reg_addr_width-1:0] WRITE_REG_i,
  input  logic [reg_word_width-1:0] WRITE_DATA_i,
  input  logic                      WRITE_EN_i
);

  localparam int N = 2 ** reg_addr_width;

  // Storage starts at index 1; register 0 is a constant, not a flop.
  logic [reg_word_width-1:0] regs [1:N-1];
  logic [reg_word_width-1:0] reg0;

  assign reg0 = '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 1; i < N; i++) begin
        regs[i] <= '0;
      end
    end else if (WRITE_EN_i && (WRITE_REG_i != '0)) begin
      regs[WRITE_REG_i] <= WRITE_DATA_i;
    end
  end

  // No write-to-read bypass: a same-address read shows the new value only after the edge.
  always_comb begin
    READ_DATA1_o = reg0;
    READ_DATA2_o = reg0;
    if (READ_REG1_i != '0) READ_DATA1_o = regs[READ_REG1_i];
    if (READ_REG2_i != '0) READ_DATA2_o = regs[READ_REG2_i];
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read values,
// a monitor process samples both read ports and compares.
module tb_reg_file;

  logic        CLK;
  logic        RST;
  logic [4:0]  READ_REG1_i, READ_REG2_i, WRITE_REG_i;
  logic [31:0] READ_DATA1_o, READ_DATA2_o, WRITE_DATA_i;
  logic        WRITE_EN_i;

  reg_file #(.reg_word_width(32), .reg_addr_width(5)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .READ_REG1_i (READ_REG1_i),
    .READ_REG2_i (READ_REG2_i),
    .READ_DATA1_o(READ_DATA1_o),
    .READ_DATA2_o(READ_DATA2_o),
    .WRITE_REG_i (WRITE_REG_i),
    .WRITE_DATA_i(WRITE_DATA_i),
    .WRITE_EN_i  (WRITE_EN_i)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event sample_ev;

  // Monitor: on each sample request, pops every queued expectation and compares.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      #1;
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = (e.port == 1) ? READ_DATA1_o : READ_DATA2_o;
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic expect2(input string nm,
                         input logic [4:0] a1, input logic [31:0] e1,
                         input logic [4:0] a2, input logic [31:0] e2);
    exp_t e;
    int   n;
    READ_REG1_i = a1;
    READ_REG2_i = a2;
    e.name = nm; e.port = 1; e.exp = e1; q.push_back(e);
    e.name = nm; e.port = 2; e.exp = e2; q.push_back(e);
    -> sample_ev;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      #1;
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s drain: %0d entries left, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  // Presents a write at the negedge; caller decides what happens around the edge.
  task automatic set_write(input logic en, input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    WRITE_EN_i   = en;
    WRITE_REG_i  = a;
    WRITE_DATA_i = d;
  endtask

  task automatic write_edge(input logic en, input logic [4:0] a, input logic [31:0] d);
    set_write(en, a, d);
    @(posedge CLK);
    #1;
    WRITE_EN_i = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    WRITE_EN_i = 1'b0; WRITE_REG_i = '0; WRITE_DATA_i = '0;
    READ_REG1_i = '0;  READ_REG2_i = '0;
    #1;
    expect2("reg0_time0", 5'd0, 32'd0, 5'd0, 32'd0);

    // Reset for two cycles; storage reads 0 both during and after
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #2;
    expect2("rst_during", 5'd1, 32'd0, 5'd16, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    expect2("rst_after_a", 5'd1, 32'd0, 5'd16, 32'd0);
    expect2("rst_after_b", 5'd31, 32'd0, 5'd0, 32'd0);

    // Write to register 0 is discarded
    write_edge(1'b1, 5'd0, 32'd11);
    expect2("zero_reg", 5'd0, 32'd0, 5'd31, 32'd0);

    // Basic write: old value before the edge, new value after
    set_write(1'b1, 5'd1, 32'd12);
    expect2("wr1_before", 5'd1, 32'd0, 5'd0, 32'd0);
    @(posedge CLK);
    #1;
    WRITE_EN_i = 1'b0;
    expect2("wr1_after", 5'd1, 32'd12, 5'd0, 32'd0);

    // Dual port and enable gating
    write_edge(1'b1, 5'd16, 32'd13);
    expect2("wr16", 5'd16, 32'd13, 5'd1, 32'd12);
    write_edge(1'b0, 5'd16, 32'd99);
    expect2("wr16_disabled", 5'd16, 32'd13, 5'd1, 32'd12);

    // Top register and both ports on the same address
    write_edge(1'b1, 5'd31, 32'd14);
    expect2("wr31", 5'd31, 32'd14, 5'd16, 32'd13);
    expect2("both31", 5'd31, 32'd14, 5'd31, 32'd14);

    // Async reset between edges clears immediately; a write edge under reset is ignored
    @(negedge CLK);
    #2;
    RST = 1'b1;
    expect2("async_rst_a", 5'd31, 32'd0, 5'd16, 32'd0);
    expect2("async_rst_b", 5'd1, 32'd0, 5'd0, 32'd0);
    set_write(1'b1, 5'd31, 32'd77);
    @(posedge CLK);
    #1;
    WRITE_EN_i = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    expect2("wr_under_rst", 5'd31, 32'd0, 5'd16, 32'd0);

    // Writes resume once reset is released
    write_edge(1'b1, 5'd16, 32'hDEAD_BEEF);
    expect2("wr_post_rst", 5'd16, 32'hDEAD_BEEF, 5'd31, 32'd0);

    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
